phase_count_gen: RTL and testbench

- Producer side of the ADPLL phase-count capture interface.
- Measures the signed phase error between the reference clock and the DCO feedback clock, as a count of fpga_clk_i cycles between their rising edges.
- Drives a stable signed counter value plus a capture trigger edge to the downstream save stage, then clears the counter for the next measurement.
- Sits between the raw ref/DCO inputs and the phase-save/loop-filter path.

---
 rtl/phase_count_gen_if.sv | 24 ++
 rtl/phase_count_gen.sv | 146 ++++++++++++++
 tb/tb_phase_count_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_count_gen_if.sv
// Signal bundle between the phase-count producer and the downstream capture stage.
// master = phase_count_gen (drives the capture outputs), slave = environment/capture side.
interface phase_count_gen_if #(
  parameter int WIDTH = 20
);
  logic                    enable_i;
  logic                    ref_clk_i;
  logic                    dco_clk_i;
  logic signed [WIDTH-1:0] counter_val_o;
  logic                    save_trigger_o;
  logic                    busy_o;
  logic                    saturated_o;
  logic                    missed_edge_o;

  modport master (
    input  enable_i, ref_clk_i, dco_clk_i,
    output counter_val_o, save_trigger_o, busy_o, saturated_o, missed_edge_o
  );

  modport slave (
    output enable_i, ref_clk_i, dco_clk_i,
    input  counter_val_o, save_trigger_o, busy_o, saturated_o, missed_edge_o
  );
endinterface

// File: rtl/phase_count_gen.sv
// ADPLL phase-count producer: measures signed ref/DCO edge distance in fpga_clk_i cycles,
// presents it stable, strobes save_trigger_o, then clears for the next measurement.
module phase_count_gen #(
  parameter int WIDTH       = 20,
  parameter int TRIG_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic                fpga_clk_i,
  input logic                reset_i,
  phase_count_gen_if.master  bus
);
  localparam int TCW = $clog2(TRIG_CYCLES + 1) + 1;
  localparam logic signed [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic signed [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [WIDTH-1:0] CNT_MONE = {WIDTH{1'b1}};
  localparam logic signed [WIDTH-1:0] CNT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] CNT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [TCW-1:0] TRIG_ONE  = {{(TCW-1){1'b0}}, 1'b1};
  localparam logic [TCW-1:0] TRIG_ZERO = {TCW{1'b0}};
  localparam logic [TCW-1:0] TRIG_LAST = TCW'(TRIG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CNT_UP, CNT_DN, SETUP, SAVE, CLEAR} state_t;

  state_t                  state_r, state_s;
  logic signed [WIDTH-1:0] counter_r, counter_s;
  logic [TCW-1:0]          trig_cnt_r, trig_cnt_s;
  logic                    sat_r, sat_s, missed_r, missed_s;
  logic                    busy_r, trig_r;
  logic [SYNC_STAGES-1:0]  ref_sync_r, dco_sync_r;
  logic                    ref_prev_r, dco_prev_r;
  logic                    ref_p_s, dco_p_s;

  // Synchronize the async clocks and keep the last synced level for rising-edge detection
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      ref_sync_r <= {SYNC_STAGES{1'b0}};
      dco_sync_r <= {SYNC_STAGES{1'b0}};
      ref_prev_r <= 1'b0;
      dco_prev_r <= 1'b0;
    end else begin
      ref_sync_r <= {ref_sync_r[SYNC_STAGES-2:0], bus.ref_clk_i};
      dco_sync_r <= {dco_sync_r[SYNC_STAGES-2:0], bus.dco_clk_i};
      ref_prev_r <= ref_sync_r[SYNC_STAGES-1];
      dco_prev_r <= dco_sync_r[SYNC_STAGES-1];
    end
  end

  assign ref_p_s = ref_sync_r[SYNC_STAGES-1] & ~ref_prev_r;
  assign dco_p_s = dco_sync_r[SYNC_STAGES-1] & ~dco_prev_r;

  // Next-state, counter, sticky flag and trigger-length decode
  always_comb begin
    state_s    = state_r;
    counter_s  = counter_r;
    sat_s      = sat_r;
    missed_s   = missed_r;
    trig_cnt_s = TRIG_ZERO;
    case (state_r)
      IDLE: begin
        if (!bus.enable_i) begin
          state_s = IDLE;
        end else if (ref_p_s && !dco_p_s) begin
          state_s   = CNT_UP;
          counter_s = CNT_ONE;
        end else if (dco_p_s && !ref_p_s) begin
          state_s   = CNT_DN;
          counter_s = CNT_MONE;
        end else if (ref_p_s && dco_p_s) begin
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      CNT_UP: begin
        if (!bus.enable_i) begin
          state_s = CLEAR;
        end else begin
          if (ref_p_s) missed_s = 1'b1;
          else         missed_s = missed_r;
          // The terminating edge freezes the count; clamp instead of wrapping
          if (dco_p_s)                   state_s   = SETUP;
          else if (counter_r == CNT_MAX) sat_s     = 1'b1;
          else                           counter_s = counter_r + CNT_ONE;
        end
      end
      CNT_DN: begin
        if (!bus.enable_i) begin
          state_s = CLEAR;
        end else begin
          if (dco_p_s) missed_s = 1'b1;
          else         missed_s = missed_r;
          if (ref_p_s)                   state_s   = SETUP;
          else if (counter_r == CNT_MIN) sat_s     = 1'b1;
          else                           counter_s = counter_r - CNT_ONE;
        end
      end
      SETUP: begin
        missed_s = missed_r | ref_p_s | dco_p_s;
        state_s  = SAVE;
      end
      SAVE: begin
        missed_s   = missed_r | ref_p_s | dco_p_s;
        trig_cnt_s = trig_cnt_r + TRIG_ONE;
        if (trig_cnt_r == TRIG_LAST) state_s = CLEAR;
        else                         state_s = SAVE;
      end
      CLEAR: begin
        missed_s  = missed_r | ref_p_s | dco_p_s;
        counter_s = CNT_ZERO;
        sat_s     = 1'b0;
        state_s   = IDLE;
      end
      default: begin
        state_s   = IDLE;
        counter_s = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs; reset forces the trigger low asynchronously
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      counter_r  <= CNT_ZERO;
      trig_cnt_r <= TRIG_ZERO;
      sat_r      <= 1'b0;
      missed_r   <= 1'b0;
      busy_r     <= 1'b0;
      trig_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      counter_r  <= counter_s;
      trig_cnt_r <= trig_cnt_s;
      sat_r      <= sat_s;
      missed_r   <= missed_s;
      busy_r     <= (state_s != IDLE);
      trig_r     <= (state_s == SAVE);
    end
  end

  assign bus.counter_val_o  = counter_r;
  assign bus.save_trigger_o = trig_r;
  assign bus.busy_o         = busy_r;
  assign bus.saturated_o    = sat_r;
  assign bus.missed_edge_o  = missed_r;
endmodule

// File: tb/tb_phase_count_gen.sv
// Scoreboard bench: one stimulus stream drives a WIDTH=20 and a WIDTH=4 instance; expected
// captures come from the ref/DCO edge distance (clamped to each width) pushed per measurement.
module tb_phase_count_gen;
  localparam int TRIG = 2;

  typedef struct {int val; bit sat; bit missed;} exp_t;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, ref_clk = 1'b0, dco_clk = 1'b0;
  int   tests = 0, fails = 0;
  bit   missed_sticky = 1'b0;
  exp_t q0[$], q1[$];

  phase_count_gen_if #(.WIDTH(20)) if20 ();
  phase_count_gen_if #(.WIDTH(4))  if4 ();

  assign if20.enable_i = enable;  assign if20.ref_clk_i = ref_clk;  assign if20.dco_clk_i = dco_clk;
  assign if4.enable_i  = enable;  assign if4.ref_clk_i  = ref_clk;  assign if4.dco_clk_i  = dco_clk;

  phase_count_gen #(.WIDTH(20), .TRIG_CYCLES(TRIG), .SYNC_STAGES(2)) u_dut20 (
    .fpga_clk_i(clk), .reset_i(rst), .bus(if20.master));
  phase_count_gen #(.WIDTH(4), .TRIG_CYCLES(TRIG), .SYNC_STAGES(2)) u_dut4 (
    .fpga_clk_i(clk), .reset_i(rst), .bus(if4.master));

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t model(int delta, int w, bit missed);
    exp_t e;
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    e.val    = (delta > hi) ? hi : (delta < lo) ? lo : delta;
    e.sat    = (e.val != delta);
    e.missed = missed;
    return e;
  endfunction

  // Monitor: per instance, pop on trigger rise, time the strobe, then check the clear to IDLE
  int val[2]; bit trg[2], bsy[2], sat[2], mis[2], prev_trg[2], post[2]; int hi_cnt[2];
  always @(negedge clk) begin
    exp_t e;
    val[0] = int'(if20.counter_val_o); trg[0] = if20.save_trigger_o; bsy[0] = if20.busy_o;
    sat[0] = if20.saturated_o;         mis[0] = if20.missed_edge_o;
    val[1] = int'(if4.counter_val_o);  trg[1] = if4.save_trigger_o;  bsy[1] = if4.busy_o;
    sat[1] = if4.saturated_o;          mis[1] = if4.missed_edge_o;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        hi_cnt[d] = 0; post[d] = 1'b0; trg[d] = 1'b0;
      end else begin
        if (trg[d] && !prev_trg[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            check($sformatf("unexpected_trigger[%0d]", d), 1, 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("capture_val[%0d]", d), val[d], e.val);
            check($sformatf("capture_sat[%0d]", d), int'(sat[d]), int'(e.sat));
            check($sformatf("capture_missed[%0d]", d), int'(mis[d]), int'(e.missed));
          end
        end
        if (trg[d]) begin
          hi_cnt[d]++;
        end else if (prev_trg[d]) begin
          check($sformatf("trigger_len[%0d]", d), hi_cnt[d], TRIG);
          hi_cnt[d] = 0; post[d] = 1'b1;
        end else if (post[d]) begin
          check($sformatf("cleared_val[%0d]", d), val[d], 0);
          check($sformatf("cleared_busy[%0d]", d), int'(bsy[d]), 0);
          check($sformatf("cleared_sat[%0d]", d), int'(sat[d]), 0);
          post[d] = 1'b0;
        end
      end
      prev_trg[d] = trg[d];
    end
  end

  task automatic set_sig(int which, logic v);
    if (which == 0) ref_clk = v; else dco_clk = v;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_val20"}, int'(if20.counter_val_o), 0);
    check({tag, "_trig20"}, int'(if20.save_trigger_o), 0);
    check({tag, "_busy20"}, int'(if20.busy_o), 0);
    check({tag, "_val4"}, int'(if4.counter_val_o), 0);
    check({tag, "_trig4"}, int'(if4.save_trigger_o), 0);
    check({tag, "_missed20"}, int'(if20.missed_edge_o), 0);
  endtask

  // delta > 0: ref leads by delta cycles; delta < 0: DCO leads
  task automatic run_pair(int delta, bit extra_cnt, bit extra_save, bit do_reset);
    int n     = (delta < 0) ? -delta : delta;
    int lead  = (delta < 0) ? 1 : 0;
    int trail = 1 - lead;
    bit seen  = 1'b0;
    if (n < 6) extra_cnt = 1'b0;
    q0.push_back(model(delta, 20, missed_sticky | extra_cnt));
    q1.push_back(model(delta, 4, missed_sticky | extra_cnt));
    missed_sticky |= extra_cnt;
    @(negedge clk);
    if (n == 0) begin
      ref_clk = 1'b1; dco_clk = 1'b1;
    end else begin
      set_sig(lead, 1'b1);
      for (int i = 1; i <= n; i++) begin
        @(negedge clk);
        if (extra_cnt && i == 2) set_sig(lead, 1'b0);
        if (extra_cnt && i == 4) set_sig(lead, 1'b1);
        if (i == n) set_sig(trail, 1'b1);
      end
    end
    if (extra_save) begin
      @(negedge clk); set_sig(trail, 1'b0);
      @(negedge clk); set_sig(trail, 1'b1);
      missed_sticky = 1'b1;
    end
    if (do_reset) begin
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = if20.save_trigger_o;
      end
      check("reset_wait_trigger", int'(seen), 1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      ref_clk = 1'b0; dco_clk = 1'b0; missed_sticky = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
      ref_clk = 1'b0; dco_clk = 1'b0;
      repeat (12) @(negedge clk);
    end
  endtask

  // Measurement started, then enable dropped mid-count: no capture may appear
  task automatic run_abort();
    @(negedge clk); ref_clk = 1'b1;
    repeat (6) @(negedge clk); enable = 1'b0;
    repeat (3) @(negedge clk); dco_clk = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_busy20", int'(if20.busy_o), 0);
    check("abort_val20", int'(if20.counter_val_o), 0);
    enable = 1'b1; ref_clk = 1'b0; dco_clk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    #1 check_reset_outputs("reset");
    check("reset_sat4", int'(if4.saturated_o), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    repeat (4) @(negedge clk);
    run_pair(10, 0, 0, 0);
    run_pair(-7, 0, 0, 0);
    run_pair(0, 0, 0, 0);
    run_pair(20, 0, 0, 0);
    run_pair(-8, 0, 0, 0);
    run_pair(8, 0, 0, 0);
    run_pair(-9, 0, 0, 0);
    for (int i = 0; i < 25; i++) begin
      d = int'($urandom_range(0, 80)) - 40;
      run_pair(d, 0, 0, 0);
    end
    check("no_missed_before_extras", int'(if20.missed_edge_o), 0);
    run_pair(15, 1, 1, 0);
    check("missed_sticky20", int'(if20.missed_edge_o), 1);
    check("missed_sticky4", int'(if4.missed_edge_o), 1);
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 60)) - 30;
      run_pair(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
    end
    run_abort();
    run_pair(9, 0, 0, 1);
    run_pair(5, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 50)) - 25;
      run_pair(d, 0, 0, 0);
    end
    repeat (20) @(negedge clk);
    check("queue_empty20", q0.size(), 0);
    check("queue_empty4", q1.size(), 0);
    check("final_missed20", int'(if20.missed_edge_o), int'(missed_sticky));
    check("final_missed4", int'(if4.missed_edge_o), int'(missed_sticky));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
